// File: rtl/mem_stage_lsu_if.sv
// EX->MEM op handshake plus MEM->WB completion and misalignment reporting.
interface mem_stage_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic [4:0]  rd;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic [2:0]  funct3;
  logic        wb_valid;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_mem_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [15:0] misalign_cnt;

  modport master (
    output in_valid, alu_result, rs2_data, rd, mem_read, mem_write,
           reg_write, mem_to_reg, funct3,
    input  in_ready, wb_valid, wb_alu_result, wb_mem_data, wb_rd,
           wb_reg_write, wb_mem_to_reg, misalign, misalign_addr, misalign_cnt
  );

  modport slave (
    input  in_valid, alu_result, rs2_data, rd, mem_read, mem_write,
           reg_write, mem_to_reg, funct3,
    output in_ready, wb_valid, wb_alu_result, wb_mem_data, wb_rd,
           wb_reg_write, wb_mem_to_reg, misalign, misalign_addr, misalign_cnt
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM stage: byte-lane data memory; aligned loads/stores finish LAT+1 cycles after acceptance, others in 1.
// Backpressure: in_ready is low only while an aligned access waits out its LAT wait states.
module mem_stage_lsu #(
  parameter int ADDR_W = 12,
  parameter int LAT    = 2
) (
  input logic          clk,
  input logic          rst_n,
  mem_stage_lsu_if.slave bus
);

  localparam int WORDS = 1 << (ADDR_W - 2);
  localparam logic [2:0] CNT_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        ld;
    logic        st;
    logic        reg_write;
    logic        mem_to_reg;
    logic [2:0]  funct3;
  } op_t;

  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  op_t op_in, op_q, op_cur;

  logic [3:0][7:0] mem [WORDS];

  logic [ADDR_W-3:0] widx;
  logic [1:0]  lane;
  logic [31:0] rword;
  logic [31:0] ldata;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        is_mem, is_h, is_w, mis, accept, fire;

  assign op_in = '{addr: bus.alu_result, data: bus.rs2_data, rd: bus.rd,
                   ld: bus.mem_read, st: bus.mem_write & ~bus.mem_read,
                   reg_write: bus.reg_write, mem_to_reg: bus.mem_to_reg,
                   funct3: bus.funct3};

  // While waiting, the latched op drives the memory port; in IDLE the live input does.
  assign op_cur = (state == WAIT) ? op_q : op_in;
  assign widx   = op_cur.addr[ADDR_W-1:2];
  assign lane   = op_cur.addr[1:0];
  assign rword  = mem[widx];
  assign is_mem = op_cur.ld | op_cur.st;
  assign is_h   = (op_cur.funct3 == 3'b001) || (op_cur.ld && op_cur.funct3 == 3'b101);
  assign is_w   = (op_cur.funct3 == 3'b010);
  assign mis    = is_mem && ((is_h && lane[0]) || (is_w && lane != 2'b00));
  assign accept = (state == IDLE) && bus.in_valid;
  assign bus.in_ready = (state == IDLE);

  always_comb begin
    ldata = 32'd0;
    case (op_cur.funct3)
      3'b000: ldata = {{24{rword[{lane, 3'b111}]}}, rword[{lane, 3'b000} +: 8]};
      3'b001: ldata = lane[1] ? {{16{rword[31]}}, rword[31:16]} : {{16{rword[15]}}, rword[15:0]};
      3'b010: ldata = rword;
      3'b100: ldata = {24'd0, rword[{lane, 3'b000} +: 8]};
      3'b101: ldata = lane[1] ? {16'd0, rword[31:16]} : {16'd0, rword[15:0]};
      default: ldata = 32'd0;
    endcase
  end

  always_comb begin
    wdata = op_cur.data;
    be    = 4'b0000;
    case (op_cur.funct3)
      3'b000: begin wdata = {4{op_cur.data[7:0]}};  be = 4'b0001 << lane; end
      3'b001: begin wdata = {2{op_cur.data[15:0]}}; be = lane[1] ? 4'b1100 : 4'b0011; end
      3'b010: begin wdata = op_cur.data;            be = 4'b1111; end
      default: begin wdata = op_cur.data;           be = 4'b0000; end
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = 3'd0;
        if (accept) begin
          if (is_mem && !mis && LAT > 0) state_nxt = WAIT;
          else                           fire      = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          fire      = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) op_q <= op_in;
    end
  end

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (fire && op_cur.st && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][i] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_valid      <= 1'b0;
      bus.wb_alu_result <= 32'd0;
      bus.wb_mem_data   <= 32'd0;
      bus.wb_rd         <= 5'd0;
      bus.wb_reg_write  <= 1'b0;
      bus.wb_mem_to_reg <= 1'b0;
      bus.misalign      <= 1'b0;
      bus.misalign_addr <= 32'd0;
      bus.misalign_cnt  <= 16'd0;
    end else begin
      bus.wb_valid <= fire;
      bus.misalign <= fire && mis;
      if (fire) begin
        bus.wb_alu_result <= op_cur.addr;
        bus.wb_mem_data   <= (op_cur.ld && !mis) ? ldata : 32'd0;
        bus.wb_rd         <= op_cur.rd;
        bus.wb_reg_write  <= op_cur.reg_write && !mis;
        bus.wb_mem_to_reg <= op_cur.mem_to_reg;
        if (mis) begin
          bus.misalign_addr <= op_cur.addr;
          if (bus.misalign_cnt != 16'hFFFF) bus.misalign_cnt <= bus.misalign_cnt + 16'd1;
        end
      end
    end
  end

endmodule
